mux4_rr_sched: RTL
==================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 mux output channel between four requesters.
- Arbitrates requests, drives the mux select pair (s1,s0) and one-hot grants, and enforces a maximum hold time per grant.
- Instantiates the 4:1 datapath internally.
- Sits between the four producers and the single shared consumer line.

Parameters:
- DW, 1, data width of each mux input and output.
- MAX_HOLD, 8, max consecutive cycles one requester keeps the grant while others wait (legal range 1 to 255).
- CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per source; bit k belongs to source k
- i0  input  DW  data of source 0
- i1  input  DW  data of source 1
- i2  input  DW  data of source 2
- i3  input  DW  data of source 3
- gnt  output  4  one-hot grant, registered
- s1  output  1  mux select MSB, registered
- s0  output  1  mux select LSB, registered
- out  output  DW  selected data = i[{s1,s0}], combinational from registered select
- out_valid  output  1  high while in GRANT, registered

Behaviour:
- Reset (async assert, sync release) gives:
  - state=IDLE, gnt=4'b0000, s1=0, s0=0, out_valid=0, hold_cnt=0.
  - Priority pointer ptr=0, so source 0 has highest priority first.
- States: IDLE, GRANT.
- Arbitration, evaluated in IDLE only:
  - Winner = first k with req[k]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If req != 0 at edge N: at edge N+1 gnt=onehot(winner), {s1,s0}=winner, out_valid=1, hold_cnt=1, state=GRANT. Latency req->gnt is 1 cycle.
  - If req == 0: all outputs hold reset values; s1/s0 keep their last value.
- GRANT, with cur = {s1,s0}:
  - Release: req[cur]=0 -> next edge gnt=0, out_valid=0, ptr=cur+1 mod 4, state=IDLE.
  - Preempt: hold_cnt==MAX_HOLD and (req & ~onehot(cur)) != 0 -> same actions as release, even though req[cur] is still 1.
  - Limit with no competitor: hold_cnt==MAX_HOLD, no other req -> stay in GRANT, hold_cnt reloads to 1.
  - Otherwise: hold_cnt increments; gnt and select are stable.
- Every grant change passes through one IDLE cycle with gnt=0 and out_valid=0 (bubble). Back-to-back grants to different sources are therefore 1 dead cycle apart.
- s1/s0 never change while out_valid=1. They retain their value in IDLE until the next grant.
- Simultaneous events:
  - Release and preempt in the same cycle -> treated as release; result is identical.
  - A req rising in the same cycle another source's grant ends is considered in the following IDLE arbitration.
- ptr wraps 3->0.
- hold_cnt never exceeds MAX_HOLD.
- MAX_HOLD=1: every grant lasts exactly one cycle when others are waiting.
- Reset asserted mid-GRANT: outputs go to reset values immediately, without waiting for a clock. ptr returns to 0.
- gnt is always one-hot or zero. gnt != 0 iff out_valid=1.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Source index constants SRC0..SRC3 = 2'd0..2'd3.
  - Default MAX_HOLD.
- Sub-module mux4_dp: parameterised DW-wide 4:1 combinational mux with ports i0..i3, s1, s0, out. It is instantiated once.
- Arbitration (rotate, priority-find, rotate back) is a function in the package.

Test Plan:
- Reset then single request: rst_n low 2 cycles then high; req=4'b0100 -> one cycle later gnt=4'b0100, {s1,s0}=2'b10, out_valid=1. With i2=1 and others 0, out=1.
- Round-robin fairness: req=4'b1111 held, MAX_HOLD=2 -> grant order 0,1,2,3,0. Each grant lasts 2 cycles followed by 1 cycle with gnt=0.
- Voluntary release: grant to source 1; drop req[1] after 3 cycles while req[3]=1 -> gnt=0 for one cycle, then gnt=4'b1000, {s1,s0}=2'b11.
- No-competitor extension: only req[0]=1 for 20 cycles, MAX_HOLD=8 -> gnt=4'b0001 continuously, never drops, out_valid stays 1.
- Async reset mid-grant: pull rst_n low between clock edges during a grant to source 2 -> gnt=0, out_valid=0, s1=s0=0 immediately. After release with req=4'b1100, source 2 is granted first (ptr=0 scan).
- Select stability: randomise i0..i3 every cycle during a grant -> out tracks i[granted] and {s1,s0} never toggles while out_valid=1.

Source files
------------

// File: rtl/mux4_rr_sched_pkg.sv
// Shared constants and the round-robin pick function for the mux4_rr_sched block.
package mux4_rr_sched_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam logic [1:0] SRC0 = 2'd0;
   localparam logic [1:0] SRC1 = 2'd1;
   localparam logic [1:0] SRC2 = 2'd2;
   localparam logic [1:0] SRC3 = 2'd3;

   localparam int DEF_MAX_HOLD = 8;

   typedef enum logic {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT
   } state_t;

   // Rotate req so ptr sits at bit 0, take the lowest set bit, rotate the index back.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [7:0] dbl;
      logic [3:0] rot;
      logic [1:0] off;
      dbl = {req, req};
      rot = 4'(dbl >> ptr);
      off = 2'd0;
      for (int j = 3; j >= 0; j--) begin
         if (rot[j]) off = 2'(j);
      end
      return ptr + off;
   endfunction

endpackage

// File: rtl/mux4_rr_sched_dp.sv
// DW-wide 4:1 combinational data mux steered by the scheduler's select pair.
module mux4_dp
   import mux4_rr_sched_pkg::*;
#(
   parameter int DW = 1
) (
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   input  logic          s1,
   input  logic          s0,
   output logic [DW-1:0] out
);

   always_comb begin
      out = i0;
      case ({s1, s0})
         SRC0:    out = i0;
         SRC1:    out = i1;
         SRC2:    out = i2;
         SRC3:    out = i3;
         default: out = i0;
      endcase
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux channel among four requesters,
// with a bounded hold time per grant and a one-cycle bubble between grants.
module mux4_rr_sched
   import mux4_rr_sched_pkg::*;
#(
   parameter int DW       = 1,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   output logic [3:0]    gnt,
   output logic          s1,
   output logic          s0,
   output logic [DW-1:0] out,
   output logic          out_valid
);

   state_t        state, state_nx;
   logic [3:0]    gnt_nx;
   logic [1:0]    sel, sel_nx;
   logic          valid_nx;
   logic [CW-1:0] hold_cnt, hold_nx;
   logic [1:0]    ptr, ptr_nx;
   logic [1:0]    winner;
   logic [3:0]    cur_oh;
   logic          at_limit;
   logic          others;

   assign s1 = sel[1];
   assign s0 = sel[0];

   assign winner   = rr_pick(req, ptr);
   assign cur_oh   = 4'b0001 << sel;
   assign at_limit = (hold_cnt == CW'(MAX_HOLD));
   assign others   = |(req & ~cur_oh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= 4'b0000;
         sel       <= 2'b00;
         out_valid <= 1'b0;
         hold_cnt  <= '0;
         ptr       <= 2'b00;
      end else begin
         state     <= state_nx;
         gnt       <= gnt_nx;
         sel       <= sel_nx;
         out_valid <= valid_nx;
         hold_cnt  <= hold_nx;
         ptr       <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      sel_nx   = sel;
      valid_nx = out_valid;
      hold_nx  = hold_cnt;
      ptr_nx   = ptr;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_nx = GRANT;
               gnt_nx   = 4'b0001 << winner;
               sel_nx   = winner;
               valid_nx = 1'b1;
               hold_nx  = CW'(1);
            end
         end
         GRANT: begin
            // A voluntary release and a limit preemption end the grant identically.
            if (!req[sel] || (at_limit && others)) begin
               state_nx = IDLE;
               gnt_nx   = 4'b0000;
               valid_nx = 1'b0;
               hold_nx  = '0;
               ptr_nx   = sel + 2'd1;
            end else if (at_limit) begin
               hold_nx = CW'(1);
            end else begin
               hold_nx = hold_cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            valid_nx = 1'b0;
            hold_nx  = '0;
         end
      endcase
   end

   mux4_dp #(.DW(DW)) u_dp (
      .i0  (i0),
      .i1  (i1),
      .i2  (i2),
      .i3  (i3),
      .s1  (s1),
      .s0  (s0),
      .out (out)
   );

endmodule
